// File: rtl/mips_shift_pkg.sv
// Shared definitions for the multi-cycle right shifter: state encoding,
// default geometry and the set of supported per-cycle step sizes.
package mips_shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int N_STEP_LEGAL = 4;
  localparam int STEP_LEGAL [N_STEP_LEGAL] = '{1, 2, 4, 8};

  // True when s is one of the supported bits-per-cycle values.
  function automatic bit step_is_legal(input int s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_STEP_LEGAL; i++) begin
      if (STEP_LEGAL[i] == s) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/shr_step.sv
// Combinational right shift by a small amount k, filling the vacated MSBs
// with a single fill bit (zero for logical, sign for arithmetic).
module shr_step #(
  parameter int WIDTH = mips_shift_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       k,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  logic [2*WIDTH-1:0] ext;

  // Prepend a word of fill bits so a plain shift brings them in from the top.
  always_comb begin
    ext  = {{WIDTH{fill}}, din};
    dout = WIDTH'(ext >> k);
  end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle logical/arithmetic right shifter with start/busy/done
// handshake. Shifts up to STEP bits per cycle; the result register only
// changes on entry to DONE, so it stays stable through later operations.
module shift_right_unit
  import mips_shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   Datain,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Dataout
);

  if (!step_is_legal(STEP)) begin : g_bad_step
    $error("shift_right_unit: STEP must be 1, 2, 4 or 8");
  end
  if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt_w
    $error("shift_right_unit: SHAMT_W must equal log2(WIDTH)");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  logic [3:0]         k;
  logic [WIDTH-1:0]   shifted;

  // Clamp this cycle's shift to the remaining amount so rem never underflows.
  always_comb begin
    if ({1'b0, rem_q} < (SHAMT_W+1)'(STEP)) k = 4'(rem_q);
    else                                    k = 4'(STEP);
  end

  shr_step #(.WIDTH(WIDTH)) u_shr_step (
    .din  (work_q),
    .k    (k),
    .fill (mode_q & sign_q),
    .dout (shifted)
  );

  // Next-state logic: accept in IDLE/DONE, iterate in SHIFT, load result on entry to DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    dout_d  = dout_q;
    case (state_q)
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - SHAMT_W'(k);
        if (rem_d == '0) begin
          state_d = S_DONE;
          dout_d  = shifted;
        end
      end
      default: begin
        if (start) begin
          work_d = Datain;
          rem_d  = shamt;
          mode_d = arith;
          sign_d = Datain[WIDTH-1];
          if (shamt != '0) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
            dout_d  = Datain;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      dout_q  <= dout_d;
    end
  end

  assign busy    = (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign Dataout = dout_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Scoreboard bench for shift_right_unit: unit 0 uses STEP=1, unit 1 uses
// STEP=4. Expected results and due cycles are queued when a start is
// accepted and checked when the matching done pulse appears.
module tb_shift_right_unit;

  localparam int W = 32;
  localparam int STEPS [2] = '{1, 4};

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [2];
  logic [31:0] datain = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        busy_v [2];
  logic        done_v [2];
  logic [31:0] dout_v [2];

  exp_t        sb [2][$];
  logic [31:0] last_dout [2];
  int          edges = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .Datain(datain),
    .shamt(shamt), .arith(arith), .busy(busy_v[0]), .done(done_v[0]),
    .Dataout(dout_v[0])
  );

  shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .Datain(datain),
    .shamt(shamt), .arith(arith), .busy(busy_v[1]), .done(done_v[1]),
    .Dataout(dout_v[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
    if (a) return $signed(d) >>> s;
    return d >> s;
  endfunction

  // Per-cycle monitor for one unit: busy window, done timing/data, result hold.
  task automatic mon(input int u);
    bit   be;
    exp_t e;
    if (!rst_n || !mon_en) return;
    be = (sb[u].size() > 0) && (edges >= sb[u][0].acc) && (edges < sb[u][0].due);
    check_eq($sformatf("u%0d_busy", u), {31'd0, busy_v[u]}, {31'd0, be});
    if (done_v[u]) begin
      if (sb[u].size() == 0) begin
        check_eq($sformatf("u%0d_spurious_done", u), 32'd1, 32'd0);
      end else begin
        e = sb[u].pop_front();
        check_eq($sformatf("u%0d_latency", u), edges, e.due);
        check_eq($sformatf("u%0d_data", u), dout_v[u], e.data);
        $display("u%0d done: Dataout=%h exp=%h edge=%0d", u, dout_v[u], e.data, edges);
        last_dout[u] = dout_v[u];
      end
    end else begin
      check_eq($sformatf("u%0d_hold", u), dout_v[u], last_dout[u]);
      if (sb[u].size() > 0 && edges >= sb[u][0].due) begin
        check_eq($sformatf("u%0d_missing_done", u), 32'd0, 32'd1);
        void'(sb[u].pop_front());
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0);
    mon(1);
  end

  // Wait for the unit to be free, drive one start and queue its expectation.
  task automatic issue(input int u, input logic [31:0] d, input logic [4:0] s, input logic a);
    exp_t e;
    int   n;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy_v[u] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check_eq($sformatf("u%0d_issue_timeout", u), 32'd0, 32'd1);
      return;
    end
    datain     = d;
    shamt      = s;
    arith      = a;
    start_v[u] = 1'b1;
    n      = (int'(s) + STEPS[u] - 1) / STEPS[u];
    e.data = ref_shift(d, s, a);
    e.acc  = edges + 1;
    e.due  = edges + 1 + n;
    sb[u].push_back(e);
    $display("u%0d start: Datain=%h shamt=%0d arith=%0d exp=%h", u, d, s, a, e.data);
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    datain     = $urandom;
    shamt      = 5'($urandom);
    arith      = 1'($urandom);
  endtask

  // Start pulse while the unit is busy; it must be ignored.
  task automatic pulse_ignored(input int u, input logic [31:0] d, input logic [4:0] s);
    @(negedge clk);
    datain     = d;
    shamt      = s;
    arith      = 1'b1;
    start_v[u] = 1'b1;
    $display("u%0d start while busy=%0d: Datain=%h (ignored)", u, busy_v[u], d);
    @(negedge clk);
    start_v[u] = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb[0].size() > 0 || sb[1].size() > 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check_eq("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    start_v[0]   = 1'b0;
    start_v[1]   = 1'b0;
    last_dout[0] = '0;
    last_dout[1] = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("u%0d_rst_busy", u), {31'd0, busy_v[u]}, 32'd0);
      check_eq($sformatf("u%0d_rst_done", u), {31'd0, done_v[u]}, 32'd0);
      check_eq($sformatf("u%0d_rst_dout", u), dout_v[u], 32'd0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // STEP=1 directed cases.
    issue(0, 32'h8000_0000, 5'd4, 1'b1);
    issue(0, 32'h8000_0000, 5'd4, 1'b0);
    issue(0, 32'h1234_5678, 5'd0, 1'b0);
    issue(0, 32'h8000_0001, 5'd31, 1'b1);
    issue(0, 32'h8000_0001, 5'd31, 1'b0);
    issue(0, 32'h0000_0100, 5'd8, 1'b0);
    pulse_ignored(0, 32'hFFFF_FFFF, 5'd1);
    issue(0, 32'h0000_0040, 5'd2, 1'b0);
    issue(0, 32'hC000_0003, 5'd1, 1'b1);
    for (int i = 0; i < 8; i++) issue(0, $urandom, 5'($urandom), 1'($urandom));
    drain();

    // STEP=4 directed cases, including non-multiple shift amounts.
    issue(1, 32'hF000_0000, 5'd7, 1'b1);
    issue(1, 32'h8000_0001, 5'd31, 1'b1);
    issue(1, 32'h8000_0001, 5'd31, 1'b0);
    issue(1, 32'hDEAD_BEEF, 5'd0, 1'b1);
    issue(1, 32'h9ABC_DEF0, 5'd4, 1'b1);
    issue(1, 32'h9ABC_DEF0, 5'd5, 1'b0);
    for (int i = 0; i < 8; i++) issue(1, $urandom, 5'($urandom), 1'($urandom));
    drain();

    // Asynchronous reset in the middle of a long operation.
    issue(0, 32'hA5A5_0000, 5'd20, 1'b1);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midop_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("midop_rst_done", {31'd0, done_v[0]}, 32'd0);
    check_eq("midop_rst_dout", dout_v[0], 32'd0);
    sb[0].delete();
    sb[1].delete();
    last_dout[0] = '0;
    last_dout[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(0, 32'h8000_0000, 5'd4, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
